// File: rtl/fpga_cmd_pkg.sv
// Shared definitions for the LED/ADC command scheduler.
// Command codes, requester and FSM encodings, host command filter helper.
package fpga_cmd_pkg;

    localparam logic [6:0] ADC_SELECT = 7'h1;
    localparam logic [6:0] RED_ON     = 7'h2;
    localparam logic [6:0] RED_OFF    = 7'h3;
    localparam logic [6:0] GREEN_ON   = 7'h4;
    localparam logic [6:0] GREEN_OFF  = 7'h5;

    localparam int LED_COUNT = 35;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    typedef enum logic {
        HOST = 1'b0,
        SCAN = 1'b1
    } req_e;

    // True when a host command names a real decoder operation with an
    // argument the decoder can act on.
    function automatic logic cmd_ok(
        input logic [6:0] cmd,
        input logic [7:0] arg,
        input int         adc_max
    );
        logic ok;
        unique case (1'b1)
            (cmd == ADC_SELECT):
                ok = (int'(arg) <= adc_max);
            (cmd >= RED_ON && cmd <= GREEN_OFF):
                ok = (int'(arg) <= LED_COUNT - 1);
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fpga_scan_timer.sv
// Periodic ADC scan request generator with round-robin channel pointer.
// Ports: clk, rst_n, scan_en, take (scan granted), scan_pend, ptr, scan_wrap.
module fpga_scan_timer
    import fpga_cmd_pkg::*;
#(
    parameter int NUM_ADC     = 18,
    parameter int SCAN_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       take,
    output logic       scan_pend,
    output logic [4:0] ptr,
    output logic       scan_wrap
);

    localparam int TW = $clog2(SCAN_PERIOD);

    logic [TW-1:0] timer;
    logic          tick;
    logic          last;

    assign tick = (timer == TW'(SCAN_PERIOD - 1));
    assign last = (ptr == 5'(NUM_ADC - 1));

    // A tick arriving while a request is still pending is dropped;
    // at most one scan request is ever outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            scan_pend <= 1'b0;
        end else if (!scan_en) begin
            timer     <= '0;
            scan_pend <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            if (take)
                scan_pend <= 1'b0;
            else if (tick)
                scan_pend <= 1'b1;
        end
    end

    // The channel pointer survives scan_en dropping so a paused scan
    // resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= take && last;
            if (take)
                ptr <= last ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_cmd_sched.sv
// Arbitrates host commands and ADC scan selects onto the decoder bus as
// setup/strobe/hold transactions.
// Ports: clk, rst_n, host_valid/cmd/data/ready, scan_en, busy, enable,
// command, data, cur_adc, scan_wrap; cmd_err with
// FPGA_CMD_SCHED_CMD_FILTER_EN defined (host command filter).
module fpga_cmd_sched
    import fpga_cmd_pkg::*;
#(
    parameter int NUM_ADC     = 18,
    parameter int SCAN_PERIOD = 1000,
    parameter int STROBE_LEN  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_valid,
    input  logic [6:0] host_cmd,
    input  logic [7:0] host_data,
    output logic       host_ready,
    input  logic       scan_en,
    output logic       busy,
    output logic       enable,
    output logic [6:0] command,
    output logic [7:0] data,
    output logic [4:0] cur_adc,
    output logic       scan_wrap
`ifdef FPGA_CMD_SCHED_CMD_FILTER_EN
    ,
    output logic       cmd_err
`endif
);

    localparam int CW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SETUP  = ST_SETUP;
    localparam logic [1:0] STROBE = ST_STROBE;
    localparam logic [1:0] HOLD   = ST_HOLD;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    req_e          rr_last;
    logic          scan_pend;
    logic [4:0]    ptr;
    logic          idle;
    logic          grant_host;
    logic          grant_scan;
    logic          host_fwd;

    fpga_scan_timer #(
        .NUM_ADC     (NUM_ADC),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .take      (grant_scan),
        .scan_pend (scan_pend),
        .ptr       (ptr),
        .scan_wrap (scan_wrap)
    );

    assign idle = (state == IDLE);
    assign busy = !idle;

    // On a tie the requester that did not win last time goes first.
    assign grant_host = idle && host_valid &&
                        (!scan_pend || rr_last == SCAN);
    assign grant_scan = idle && scan_pend &&
                        (!host_valid || rr_last == HOST);

    // Gated by rst_n so a held host_valid is never acknowledged in reset.
    assign host_ready = rst_n && grant_host;

`ifdef FPGA_CMD_SCHED_CMD_FILTER_EN
    assign host_fwd = cmd_ok(host_cmd, host_data, 2 * NUM_ADC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmd_err <= 1'b0;
        else
            cmd_err <= grant_host && !host_fwd;
    end
`else
    assign host_fwd = 1'b1;
`endif

    // command/data only move on a grant, so they are stable for the
    // whole setup/strobe/hold window the decoder samples in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            enable  <= 1'b0;
            command <= '0;
            data    <= '0;
            cur_adc <= '0;
            rr_last <= SCAN;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_host) begin
                        rr_last <= HOST;
                        if (host_fwd) begin
                            state   <= SETUP;
                            command <= host_cmd;
                            data    <= host_data;
                        end
                    end else if (grant_scan) begin
                        rr_last <= SCAN;
                        state   <= SETUP;
                        command <= ADC_SELECT;
                        data    <= 8'({ptr, 1'b0});
                        cur_adc <= ptr;
                    end
                end
                SETUP: begin
                    state  <= STROBE;
                    enable <= 1'b1;
                    cnt    <= '0;
                end
                STROBE: begin
                    if (cnt == CW'(STROBE_LEN - 1)) begin
                        state  <= HOLD;
                        enable <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
